// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encoding, nibble width and the index-width helpers used by the top level.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // A single-nibble adder still needs a one-bit index register.
    function automatic int idx_width(input int nibbles);
        return (clog2(nibbles) < 1) ? 1 : clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla_4bit.sv
// Four-bit carry-lookahead adder slice (cla_4bit), purely combinational.
// Every carry is formed directly from generate/propagate terms, so nothing ripples inside the slice.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [3:0] s
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    assign carry[0] = cin;
    assign carry[1] = gen[0]
                    | (prop[0] & cin);
    assign carry[2] = gen[1]
                    | (prop[1] & gen[0])
                    | (prop[1] & prop[0] & cin);
    assign carry[3] = gen[2]
                    | (prop[2] & gen[1])
                    | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & cin);
    assign carry[4] = gen[3]
                    | (prop[3] & gen[2])
                    | (prop[3] & prop[2] & gen[1])
                    | (prop[3] & prop[2] & prop[1] & gen[0])
                    | (prop[3] & prop[2] & prop[1] & prop[0] & cin);

    assign s    = prop ^ carry[3:0];
    assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one cla_4bit slice across WIDTH/4 cycles, with valid/ready on both sides.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    import nibble_serial_adder_pkg::*;

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             in_ready_q, in_ready_d;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                nib_cout;
    logic                last_nib;

    assign last_nib = (idx_q == LAST_IDX);

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    cla_4bit u_cla (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .cout (nib_cout),
        .s    (s_nib)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = s_nib;
                    end
                end
                carry_d = nib_cout;
                idx_d   = idx_q + 1'b1;
                if (last_nib) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so that in_ready stays low for the whole time rst is held.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow needs the top sum bit, which only exists in the last BUSY cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && in_valid && in_ready_q) begin
            ovf_d = 1'b0;
        end else if (state_q == BUSY && last_nib) begin
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): vector table, scoreboard queue, corner sequences.
// Define NIBBLE_SERIAL_ADDER_OVF_EN for both RTL and bench to also check ovf.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NUM_VECS = 10;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    vec_t vecs [NUM_VECS];
    exp_t exp_q [$];
    int   total;
    int   bad;
    time  accept_time;
    time  issue_times [3];

    nibble_serial_adder #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s timed out at %0t", name, $time);
    endtask

    // Waits for in_ready, presents one operand pair for exactly the accept edge, then scrambles inputs.
    task automatic applyStimulus(input vec_t v, output time t_accept);
        int   guard;
        exp_t e;
        guard    = 0;
        t_accept = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            reportTimeout("in_ready_wait");
            return;
        end
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        @(posedge clk);
        t_accept = $time;
        e.sum    = v.exp_sum;
        e.cout   = v.exp_cout;
        e.ovf    = v.exp_ovf;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
    endtask

    // Returns the number of negedges until out_valid is seen (bounded).
    task automatic waitOutValid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runVector(input vec_t v);
        int lat;
        applyStimulus(v, accept_time);
        waitOutValid(lat);
        if (!out_valid) begin
            reportTimeout("out_valid_wait");
            return;
        end
        checkOutput("latency", 32'(lat), 32'd4);
        checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_valid_after_accept", 32'(out_valid), 32'd0);
        checkOutput("in_ready_after_accept", 32'(in_ready), 32'd1);
    endtask

    // Scoreboard: a result is consumed at the posedge following a negedge where valid and ready are both high.
    always begin : scoreboard
        exp_t e;
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                reportTimeout("unexpected_output_no_pending_op");
            end else begin
                e = exp_q.pop_front();
                checkOutput("sum", 32'(sum), 32'(e.sum));
                checkOutput("cout", 32'(cout), 32'(e.cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        int lat;
        int guard;
        vec_t noise;

        vecs[0] = '{a: 16'h1234, b: 16'h1111, cin: 1'b0, exp_sum: 16'h2345, exp_cout: 1'b0, exp_ovf: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, exp_sum: 16'h0000, exp_cout: 1'b1, exp_ovf: 1'b0};
        vecs[2] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, exp_sum: 16'h0000, exp_cout: 1'b1, exp_ovf: 1'b1};
        vecs[3] = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, exp_sum: 16'h0100, exp_cout: 1'b0, exp_ovf: 1'b0};
        vecs[4] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, exp_sum: 16'h8000, exp_cout: 1'b0, exp_ovf: 1'b1};
        vecs[5] = '{a: 16'hABCD, b: 16'h1234, cin: 1'b1, exp_sum: 16'hBE02, exp_cout: 1'b0, exp_ovf: 1'b0};
        vecs[6] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, exp_sum: 16'hFFFF, exp_cout: 1'b1, exp_ovf: 1'b0};
        vecs[7] = '{a: 16'h0F0F, b: 16'hF0F0, cin: 1'b0, exp_sum: 16'hFFFF, exp_cout: 1'b0, exp_ovf: 1'b0};
        vecs[8] = '{a: 16'h8000, b: 16'hFFFF, cin: 1'b0, exp_sum: 16'h7FFF, exp_cout: 1'b1, exp_ovf: 1'b1};
        vecs[9] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, exp_sum: 16'h0000, exp_cout: 1'b0, exp_ovf: 1'b0};

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        $display("[TB] reset checks");
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_release", 32'(in_ready), 32'd1);

        $display("[TB] vector table");
        for (int i = 0; i < NUM_VECS; i++) begin
            runVector(vecs[i]);
        end

        $display("[TB] backpressure");
        applyStimulus(vecs[2], accept_time);
        waitOutValid(lat);
        checkOutput("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_out_valid_held", 32'(out_valid), 32'd1);
            checkOutput("bp_sum_stable", 32'(sum), 32'h0000);
            checkOutput("bp_cout_stable", 32'(cout), 32'd1);
            checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            checkOutput("bp_ovf_stable", 32'(ovf), 32'd1);
`endif
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_out_valid_dropped", 32'(out_valid), 32'd0);

        $display("[TB] busy ignore");
        applyStimulus(vecs[0], accept_time);
        noise    = '{a: 16'h0001, b: 16'h0000, cin: 1'b0, exp_sum: 16'h0000, exp_cout: 1'b0, exp_ovf: 1'b0};
        a        = noise.a;
        b        = noise.b;
        cin      = noise.cin;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("busy_in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("busy_out_valid", 32'(out_valid), 32'd1);
        checkOutput("busy_in_ready_low_done", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("busy_in_ready_back", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("busy_no_ghost_output", 32'(out_valid), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(vecs[1], accept_time);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_sum", 32'(sum), 32'd0);
        checkOutput("midrst_cout", 32'(cout), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_ready_release", 32'(in_ready), 32'd1);
        repeat (6) @(negedge clk);
        checkOutput("midrst_no_output", 32'(out_valid), 32'd0);
        runVector(vecs[3]);

        $display("[TB] back-to-back");
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(vecs[4 + k], accept_time);
            issue_times[k] = accept_time;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        checkOutput("b2b_interval_1", 32'(issue_times[1] - issue_times[0]), 32'd60);
        checkOutput("b2b_interval_2", 32'(issue_times[2] - issue_times[1]), 32'd60);

        repeat (2) @(negedge clk);
        checkOutput("pending_results", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that processes one 4-bit nibble per clock through a single `cla_4bit` slice, rippling the carry through a register between cycles. It sits directly downstream of operand sources and wraps the `cla_4bit` stage. It accepts operand pairs over a valid/ready handshake and returns the registered sum and carry-out over a second valid/ready handshake. It trades latency for area wherever a full-width adder is not justified.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and ≥ 4
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair a/b/cin valid
- in_ready  output  1  block can accept operands (IDLE only)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to least-significant nibble
- out_valid  output  1  sum/cout valid, held until accepted
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, low WIDTH bits
- cout  output  1  carry out of most-significant nibble
- ovf  output  1  signed overflow (present only with NIBBLE_SERIAL_ADDER_OVF_EN)

## Operation
- NIB = WIDTH/4 nibbles; nibble index counter width = clog2(NIB), minimum 1.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, latch a, b; carry_q ← cin; idx ← 0; sum_q ← 0; go to BUSY.
  - BUSY: drive `cla_4bit` with a_q[4*idx+:4], b_q[4*idx+:4], carry_q. Register s into sum_q[4*idx+:4] and cout into carry_q; idx ← idx+1. When idx == NIB-1 at the edge, go to DONE.
  - DONE: out_valid=1; sum=sum_q; cout=carry_q. On out_ready go to IDLE.
- Operands are latched; a/b/cin may change freely after acceptance.
- in_valid is ignored outside IDLE; there is no queueing.
- out_valid, once high, stays high with sum/cout stable until out_ready is sampled high.
- Arithmetic is unsigned modulo 2^WIDTH; carry out of bit WIDTH-1 appears only on cout.
- Reset (any state, including mid-BUSY): state ← IDLE; sum_q, carry_q, idx, a_q, b_q ← 0. Any in-flight operation is discarded with no output.
- Reset values: in_ready=0 while rst is high, 1 from the first cycle after release; out_valid=0; sum=0; cout=0; ovf=0.

## Timing
- Accept edge E0; nibble i is computed in the cycle after E0+i; out_valid rises after edge E0+NIB (latency NIB cycles; 4 for WIDTH=16).
- out_ready already high when out_valid rises: result is consumed at the next edge and in_ready returns high in the following cycle.
- Minimum issue interval: NIB+2 cycles (6 for WIDTH=16).
- The `cla_4bit` path (combinational) plus the sum/carry register is the only critical path; it is independent of WIDTH.
- All outputs are driven from registers or decoded directly from the state register. There is no combinational path from in_valid/out_ready to any output.

## Configuration
- NIBBLE_SERIAL_ADDER_OVF_EN defined:
  - Adds the ovf port and a 1-bit register.
  - In the last BUSY cycle, ovf ← (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[3] != a_q[WIDTH-1]).
  - ovf is valid and held alongside sum in DONE and cleared on reset.
- Not defined: no ovf port, no register; behaviour is otherwise identical.

## Structure
- Shared package `nibble_serial_adder_pkg`:
  - state enum IDLE/BUSY/DONE
  - nibble width constant 4
  - clog2 helper function
- One sub-module: the existing `cla_4bit`, instantiated once and unmodified (ports a, b, cin, cout, s).
- Top level contains the FSM, operand/sum/carry registers and the index counter.

## Test plan
All cases use WIDTH=16.
- Basic add: a=0x1234, b=0x1111, cin=0 → after 4 cycles out_valid=1, sum=0x2345, cout=0.
- Full ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1; carry propagates through all four nibbles.
- Backpressure: a=0x8000, b=0x8000, cin=0, out_ready low 10 cycles → out_valid held, sum=0x0000, cout=1 stable, in_ready=0 throughout; with OVF_EN, ovf=1.
- Busy ignore: second in_valid with a=0x0001 during BUSY → ignored; first result unchanged; in_ready=0 until after output handshake.
- Reset mid-operation: assert rst in the 2nd BUSY cycle → next cycle out_valid=0, sum=0, cout=0; a fresh add 0x00FF+0x0001 → sum=0x0100, cout=0.
- Back-to-back: out_ready tied high, three ops → issue interval exactly 6 cycles; 0x7FFF+0x0001 with OVF_EN gives ovf=1, sum=0x8000.
